// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler:
// controller opcodes and scheduler state encoding.
package lcd_pkg;

   localparam logic [2:0] CMD_WRITE   = 3'd0;
   localparam logic [2:0] SHIFT_UP    = 3'd1;
   localparam logic [2:0] SHIFT_DOWN  = 3'd2;
   localparam logic [2:0] SHIFT_LEFT  = 3'd3;
   localparam logic [2:0] SHIFT_RIGHT = 3'd4;
   localparam logic [2:0] AVERAGE     = 3'd5;
   localparam logic [2:0] MIRROR_X    = 3'd6;
   localparam logic [2:0] MIRROR_Y    = 3'd7;

   typedef enum logic [2:0] {
      S_INIT_WAIT = 3'd0,
      S_IDLE      = 3'd1,
      S_GUARD     = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_FINISHED  = 3'd4
   } sched_state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous 3-bit command FIFO with combinational head.
// Ports: clk, reset (sync, active-high), push/din, pop/head,
// count (entries held), empty, full. Push when full and pop
// when empty are ignored.
module lcd_cmd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [2:0]               din,
   input  logic                     pop,
   output logic [2:0]               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Schedules buffered host commands into the LCD controller.
// Ports: clk, reset (sync, active-high); host_cmd/host_valid/
// host_ready host side; cmd/cmd_valid/busy/done controller
// side; fifo_count, issued_cnt, all_done, timeout_err status.
module lcd_cmd_sched
   import lcd_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int GAP     = 3,
   parameter int TIMEOUT = 200
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2:0]             host_cmd,
   input  logic                   host_valid,
   output logic                   host_ready,
   output logic [2:0]             cmd,
   output logic                   cmd_valid,
   input  logic                   busy,
   input  logic                   done,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [7:0]             issued_cnt,
   output logic                   all_done,
   output logic                   timeout_err
);

   sched_state_t state;
   sched_state_t state_d;

   logic       write_seen;
   logic [7:0] gap_cnt;
   logic [7:0] wd;
   logic [2:0] head;
   logic       empty;
   logic       full;
   logic       push;
   logic       issue;
   logic       head_is_write;
   logic       guard_last;
   logic       wd_hit;

   // Once a WRITE is queued nothing else may follow it.
   assign host_ready = !full && !write_seen;
   assign push       = host_valid && host_ready;

   lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (host_cmd),
      .pop   (issue),
      .head  (head),
      .count (fifo_count),
      .empty (empty),
      .full  (full)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_INIT_WAIT;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         S_INIT_WAIT: if (!busy) state_d = S_IDLE;
         S_IDLE: begin
            if (issue)
               state_d = head_is_write ? S_WAIT_DONE : S_GUARD;
         end
         S_GUARD:     if (guard_last) state_d = S_IDLE;
         S_WAIT_DONE: if (done || wd_hit) state_d = S_FINISHED;
         S_FINISHED:  state_d = S_FINISHED;
         default:     state_d = S_INIT_WAIT;
      endcase
   end

   always_comb begin
      issue         = (state == S_IDLE) && !empty && !busy;
      head_is_write = (head == CMD_WRITE);
      guard_last    = (gap_cnt == 8'd1);
      // wd counts completed WAIT_DONE cycles before this one.
      wd_hit        = (wd == 8'(TIMEOUT - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd         <= 3'd0;
         cmd_valid   <= 1'b0;
         issued_cnt  <= 8'd0;
         all_done    <= 1'b0;
         timeout_err <= 1'b0;
         write_seen  <= 1'b0;
         gap_cnt     <= 8'd0;
         wd          <= 8'd0;
      end else begin
         cmd_valid <= issue;
         if (issue) begin
            cmd <= head;
            if (issued_cnt != 8'hFF)
               issued_cnt <= issued_cnt + 8'd1;
         end
         if (push && host_cmd == CMD_WRITE)
            write_seen <= 1'b1;
         if (issue)
            gap_cnt <= 8'(GAP);
         else if (state == S_GUARD)
            gap_cnt <= gap_cnt - 8'd1;
         if (issue)
            wd <= 8'd0;
         else if (state == S_WAIT_DONE)
            wd <= wd + 8'd1;
         // done has priority over a coincident timeout.
         if (state == S_WAIT_DONE) begin
            if (done)        all_done    <= 1'b1;
            else if (wd_hit) timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed and randomized checks of lcd_cmd_sched against
// an issue-order/spacing queue model.
module tb_lcd_cmd_sched;
   import lcd_pkg::*;

   localparam int DEPTH   = 8;
   localparam int GAP     = 3;
   localparam int TIMEOUT = 200;

   logic       clk;
   logic       reset;
   logic [2:0] host_cmd;
   logic       host_valid;
   logic       host_ready;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       busy;
   logic       done;
   logic [3:0] fifo_count;
   logic [7:0] issued_cnt;
   logic       all_done;
   logic       timeout_err;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int p_cyc[$];
   logic [2:0] p_cmd[$];

   logic [2:0] seq2 [4];
   logic [2:0] d3 [9];
   logic [2:0] w4 [3];
   logic       r4 [3];
   int b0, c0, r, w, s;

   logic [2:0] mq[$];
   int   last_p;
   int   m_iss;
   bit   init_ok;
   bit   exp_p;
   logic [2:0] exp_c;
   bit   rdy;
   bit   hv;
   bit   bz;
   logic [2:0] hc;

   lcd_cmd_sched #(
      .DEPTH   (DEPTH),
      .GAP     (GAP),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .host_cmd    (host_cmd),
      .host_valid  (host_valid),
      .host_ready  (host_ready),
      .cmd         (cmd),
      .cmd_valid   (cmd_valid),
      .busy        (busy),
      .done        (done),
      .fifo_count  (fifo_count),
      .issued_cnt  (issued_cnt),
      .all_done    (all_done),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   // One cycle: outputs sampled at the falling edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (cmd_valid === 1'b1) begin
         p_cyc.push_back(cyc);
         p_cmd.push_back(cmd);
      end
   endtask

   task automatic do_reset(input logic b);
      reset      = 1'b1;
      host_valid = 1'b0;
      done       = 1'b0;
      busy       = b;
      tick();
      reset = 1'b0;
      p_cyc.delete();
      p_cmd.delete();
   endtask

   // k = WAIT_DONE cycle (1-based) carrying done; 0 = never.
   task automatic write_case(input int k);
      int wc;
      do_reset(1'b0);
      host_valid = 1'b1;
      host_cmd   = CMD_WRITE;
      tick();
      host_valid = 1'b0;
      for (int j = 0; j < 10 && p_cyc.size() == 0; j++) tick();
      chk("t5_write_issued", p_cyc.size(), 1);
      wc = (p_cyc.size() > 0) ? p_cyc[0] : cyc;
      while (cyc < wc + TIMEOUT - 1) begin
         done = (k != 0) && (cyc == wc + k - 1);
         tick();
      end
      chk("t5_all_199", all_done, (k != 0 && k < TIMEOUT));
      chk("t5_to_199", timeout_err, 0);
      done = (k != 0) && (cyc == wc + k - 1);
      tick();
      done = 1'b0;
      chk("t5_all_200", all_done, (k != 0));
      chk("t5_to_200", timeout_err, (k == 0));
      repeat (5) tick();
      chk("t5_no_reissue", p_cyc.size(), 1);
      chk("t5_issued", issued_cnt, 1);
   endtask

   initial begin
      reset      = 1'b1;
      host_valid = 1'b0;
      host_cmd   = 3'd0;
      busy       = 1'b1;
      done       = 1'b0;

      // Init gating.
      do_reset(1'b1);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_issued", issued_cnt, 0);
      chk("rst_all_done", all_done, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_ready", host_ready, 1);
      for (int i = 0; i < 70; i++) begin
         host_valid = (i == 5);
         host_cmd   = SHIFT_UP;
         tick();
      end
      host_valid = 1'b0;
      chk("t1_no_issue_busy", p_cyc.size(), 0);
      chk("t1_count", fifo_count, 1);
      busy = 1'b0;
      b0   = cyc;
      tick();
      chk("t1_valid_b1", cmd_valid, 0);
      tick();
      chk("t1_valid_b2", cmd_valid, 1);
      chk("t1_cmd", cmd, SHIFT_UP);
      chk("t1_issued", issued_cnt, 1);
      chk("t1_when", cyc, b0 + 2);

      // Back-to-back pushes, guard spacing.
      repeat (6) tick();
      p_cyc.delete();
      p_cmd.delete();
      seq2 = '{SHIFT_UP, SHIFT_LEFT, AVERAGE, MIRROR_X};
      c0   = cyc;
      for (int i = 0; i < 4; i++) begin
         host_valid = 1'b1;
         host_cmd   = seq2[i];
         tick();
      end
      host_valid = 1'b0;
      repeat (20) tick();
      chk("t2_pulses", p_cyc.size(), 4);
      for (int i = 0; i < 4 && i < p_cyc.size(); i++) begin
         chk("t2_cmd", p_cmd[i], seq2[i]);
         chk("t2_cyc", p_cyc[i], c0 + 2 + (GAP + 1) * i);
      end
      chk("t2_count", fifo_count, 0);
      chk("t2_issued", issued_cnt, 5);

      // Full FIFO and backpressure.
      busy = 1'b1;
      for (int i = 0; i < 9; i++) d3[i] = 3'($urandom_range(1, 7));
      for (int i = 0; i < 9; i++) begin
         chk("t3_ready", host_ready, (i < DEPTH));
         host_valid = 1'b1;
         host_cmd   = d3[i];
         tick();
      end
      host_valid = 1'b0;
      chk("t3_count_full", fifo_count, DEPTH);
      chk("t3_ready_full", host_ready, 0);
      p_cyc.delete();
      p_cmd.delete();
      busy = 1'b0;
      repeat (40) tick();
      chk("t3_pulses", p_cyc.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < p_cmd.size(); i++)
         chk("t3_order", p_cmd[i], d3[i]);
      chk("t3_issued", issued_cnt, 13);
      chk("t3_count_end", fifo_count, 0);

      // Terminal WRITE.
      do_reset(1'b0);
      r  = cyc;
      w4 = '{AVERAGE, CMD_WRITE, SHIFT_DOWN};
      r4 = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         chk("t4_ready", host_ready, r4[i]);
         host_valid = 1'b1;
         host_cmd   = w4[i];
         tick();
      end
      host_valid = 1'b0;
      for (int j = 0; j < 40 && p_cyc.size() < 2; j++) tick();
      chk("t4_pulses", p_cyc.size(), 2);
      w = cyc;
      if (p_cyc.size() >= 2) begin
         chk("t4_cmd0", p_cmd[0], AVERAGE);
         chk("t4_cmd1", p_cmd[1], CMD_WRITE);
         w = p_cyc[1];
         chk("t4_write_when", w, r + 6);
      end
      while (cyc < w + 66) tick();
      chk("t4_all_before", all_done, 0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t4_all_done", all_done, 1);
      chk("t4_timeout", timeout_err, 0);
      repeat (20) tick();
      chk("t4_no_more", p_cyc.size(), 2);
      chk("t4_issued", issued_cnt, 2);
      chk("t4_count", fifo_count, 0);
      chk("t4_ready_after", host_ready, 0);

      // Watchdog and done/timeout boundaries.
      write_case(0);
      write_case(TIMEOUT - 1);
      write_case(TIMEOUT);

      // Reset in the middle of a guard interval.
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) begin
         host_valid = 1'b1;
         host_cmd   = (i == 0) ? SHIFT_UP : MIRROR_Y;
         tick();
      end
      host_valid = 1'b0;
      chk("t6_count_pre", fifo_count, 3);
      chk("t6_issued_pre", issued_cnt, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      busy  = 1'b1;
      chk("t6_count", fifo_count, 0);
      chk("t6_valid", cmd_valid, 0);
      chk("t6_issued", issued_cnt, 0);
      chk("t6_cmd", cmd, 0);
      chk("t6_ready", host_ready, 1);
      p_cyc.delete();
      p_cmd.delete();
      repeat (5) tick();
      chk("t6_no_stale", p_cyc.size(), 0);
      busy       = 1'b0;
      s          = cyc;
      host_valid = 1'b1;
      host_cmd   = SHIFT_RIGHT;
      tick();
      host_valid = 1'b0;
      repeat (15) tick();
      chk("t6_pulses", p_cyc.size(), 1);
      if (p_cyc.size() > 0) begin
         chk("t6_new_cmd", p_cmd[0], SHIFT_RIGHT);
         chk("t6_new_when", p_cyc[0], s + 2);
      end

      // Randomized traffic against the queue model.
      do_reset(1'b0);
      mq.delete();
      last_p  = -1000;
      init_ok = 1'b0;
      exp_p   = 1'b0;
      exp_c   = 3'd0;
      m_iss   = 0;
      for (int i = 0; i < 1500; i++) begin
         chk("rnd_valid", cmd_valid, exp_p);
         if (exp_p) chk("rnd_cmd", cmd, exp_c);
         chk("rnd_count", fifo_count, mq.size());
         rdy = (mq.size() < DEPTH);
         chk("rnd_ready", host_ready, rdy);
         chk("rnd_issued", issued_cnt, m_iss);
         hv = ($urandom_range(0, 9) < 6);
         hc = 3'($urandom_range(1, 7));
         bz = ($urandom_range(0, 3) == 0);
         host_valid = hv;
         host_cmd   = hc;
         busy       = bz;
         exp_p = init_ok && (mq.size() > 0) && !bz &&
                 (cyc >= last_p + GAP);
         if (exp_p) begin
            exp_c  = mq.pop_front();
            last_p = cyc + 1;
            if (m_iss < 255) m_iss++;
         end
         if (hv && rdy) mq.push_back(hc);
         if (!init_ok && !bz) init_ok = 1'b1;
         tick();
      end
      host_valid = 1'b0;
      chk("rnd_final_valid", cmd_valid, exp_p);
      chk("rnd_final_issued", issued_cnt, m_iss);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_sched.md
Name: lcd_cmd_sched

Overview:
Command scheduler that sits between a host/testbench command source and the LCD image controller.
- Buffers host commands in a small FIFO.
- Waits for the controller's post-reset image load to finish.
- Issues one command at a time as a single-cycle cmd/cmd_valid pulse, spaced by a guard interval and gated on busy.
- Treats WRITE (3'b000) as terminal: issues it, waits for done, then reports completion or timeout.

Parameters:
- DEPTH, 8, command FIFO depth; power of two, 2..16.
- GAP, 3, guard cycles after each non-WRITE issue; must be >= 1. The default covers a 3-cycle AVERAGE.
- TIMEOUT, 200, maximum cycles in WAIT_DONE before the error path; must be < 256.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- host_cmd  in  3  command opcode from host
- host_valid  in  1  host offers host_cmd
- host_ready  out  1  scheduler accepts host_cmd this cycle
- cmd  out  3  opcode to LCD controller
- cmd_valid  out  1  one-cycle issue strobe to LCD controller
- busy  in  1  LCD controller busy
- done  in  1  LCD controller write-out complete
- fifo_count  out  $clog2(DEPTH)+1  entries held
- issued_cnt  out  8  commands issued, saturating at 255
- all_done  out  1  sticky: WRITE completed
- timeout_err  out  1  sticky: done not seen within TIMEOUT

Behaviour:
- Reset is synchronous and active-high: one clock, clk; reset sampled only on the rising edge. Reset clears:
  - FIFO pointers and count, issued_cnt, all_done, timeout_err
  - cmd=0, cmd_valid=0
  - state=INIT_WAIT, write_seen=0
- A reset asserted mid-operation aborts everything at that edge; queued commands are discarded.
- Host handshake:
  - host_ready = (fifo_count < DEPTH) && !write_seen, from registered state only.
  - A push occurs when host_valid && host_ready. A pushed WRITE sets write_seen; all later pushes are refused until reset.
  - Push and pop in the same cycle are legal; count is unchanged.
  - A push into a full FIFO cannot occur.
- States: INIT_WAIT, IDLE, GUARD, WAIT_DONE, FINISHED.
  - INIT_WAIT: on busy==0 go to IDLE; no issue in this cycle.
  - IDLE: if fifo_count>0 && busy==0, then pop head, register cmd<=head, cmd_valid<=1, issued_cnt++ (saturating).
    - Head == WRITE: go to WAIT_DONE and clear the watchdog.
    - Otherwise: go to GUARD with gap_cnt=GAP.
    - Otherwise stay in IDLE.
  - GUARD: lasts exactly GAP cycles, then IDLE. The busy level is ignored during GUARD.
  - WAIT_DONE: watchdog increments each cycle.
    - done==1: go to FINISHED and set all_done.
    - Watchdog reaches TIMEOUT before done: go to FINISHED and set timeout_err.
    - If done and the timeout coincide, done wins.
  - FINISHED: absorbing until reset; never issues.
- Timing:
  - Issue latency: a head entry present with busy low in IDLE at cycle N gives cmd_valid high in cycle N+1.
  - Minimum pulse-to-pulse spacing is GAP+1 cycles.
  - cmd_valid is high exactly one cycle per issue. cmd holds its last issued value otherwise.
- FIFO empty in IDLE: wait; no underflow possible.
- done asserting outside WAIT_DONE is ignored.
- All outputs are registered, except host_ready and fifo_count, which are decoded from registers.

Decomposition:
- Shared package lcd_pkg:
  - Opcode constants CMD_WRITE=0, SHIFT_UP=1, SHIFT_DOWN=2, SHIFT_LEFT=3, SHIFT_RIGHT=4, AVERAGE=5, MIRROR_X=6, MIRROR_Y=7.
  - Scheduler state encoding.
- One sub-module, lcd_cmd_fifo: synchronous FIFO, 3-bit data, parameter DEPTH, with push/pop/count/empty/full. The head is visible combinationally.
- FSM, guard counter, watchdog and status counters stay in lcd_cmd_sched.

Test Plan:
1. Init gating: reset, busy held 1 for 70 cycles, push SHIFT_UP at cycle 5 -> no cmd_valid while busy=1. cmd_valid=1 with cmd=1 two cycles after busy falls. issued_cnt=1.
2. Spacing: busy=0, push 1,3,5,6 back-to-back -> four single-cycle pulses, cmd=1,3,5,6 in order, each exactly 4 cycles apart with GAP=3. fifo_count ends at 0.
3. Full/backpressure: with busy=1 after init, push 9 commands -> host_ready low after the 8th. fifo_count=8, 9th not accepted. On drain, all 8 are issued in order.
4. Terminal WRITE: push AVERAGE, WRITE, SHIFT_DOWN -> host_ready low once WRITE is accepted, so SHIFT_DOWN is refused. AVERAGE then WRITE issued. Pulse done at 66 cycles after the WRITE issue -> all_done=1 next cycle, no further cmd_valid, issued_cnt=2.
5. Timeout: issue WRITE, done held 0 -> timeout_err=1 after 200 WAIT_DONE cycles, all_done=0. A done pulse at cycle 199 instead gives all_done=1, timeout_err=0.
6. Mid-op reset: 3 entries queued during GUARD, assert reset one cycle -> fifo_count=0, cmd_valid=0, issued_cnt=0, state INIT_WAIT. No stale command issued after release.
